// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative 32-bit MULT/MULTU/DIV/DIVU engine that owns the HI/LO registers.
// Define MULDIV_DIV_EN to include the restoring divider; without it only multiplies run.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [1:0]  op_type,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] mt_data,
  input  logic        mf_req,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mb_q, mb_d;      // |op_b|: multiplicand or divisor
  logic [31:0] p_hi_q, p_hi_d;  // product high half / remainder
  logic [31:0] p_lo_q, p_lo_d;  // remaining multiplier bits / quotient
  logic        sa_q, sa_d, sb_q, sb_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;
  logic        op_ok, accept;
  logic [32:0] add_sum;
  logic [63:0] prod;
`ifdef MULDIV_DIV_EN
  logic        is_div_q, is_div_d, b_zero_q, b_zero_d;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic [31:0] quot, rem;
`endif

  assign busy  = (state_q != IDLE);
  assign stall = busy & (op_valid | mf_req | mthi | mtlo);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch can be inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    mb_d    = mb_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MULDIV_DIV_EN
    op_ok    = 1'b1;
    is_div_d = is_div_q;
    b_zero_d = b_zero_q;
    shifted  = {p_hi_q, p_lo_q[31]};
    diff     = {1'b0, shifted} - {2'b00, mb_q};
    quot     = (sa_q ^ sb_q) ? -p_lo_q : p_lo_q;
    rem      = sa_q ? -p_hi_q : p_hi_q;
`else
    op_ok    = ~op_type[1];
`endif
    accept  = op_valid & ~busy & ~flush & op_ok;
    add_sum = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, mb_q} : 33'd0);
    prod    = (sa_q ^ sb_q) ? -{p_hi_q, p_lo_q} : {p_hi_q, p_lo_q};

    if (flush && busy) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = CALC;
            cnt_d   = 5'd0;
            sa_d    = ~op_type[0] & op_a[31];
            sb_d    = ~op_type[0] & op_b[31];
            p_hi_d  = 32'd0;
            p_lo_d  = sa_d ? -op_a : op_a;
            mb_d    = sb_d ? -op_b : op_b;
`ifdef MULDIV_DIV_EN
            is_div_d = op_type[1];
            b_zero_d = (op_b == 32'd0);
`endif
          end else begin
            if (mthi) hi_d = mt_data;
            if (mtlo) lo_d = mt_data;
          end
        end
        CALC: begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = FIN;
`ifdef MULDIV_DIV_EN
          if (is_div_q) begin
            // Restoring step: keep the trial difference only when it did not go negative.
            if (!diff[33]) begin
              p_hi_d = diff[31:0];
              p_lo_d = {p_lo_q[30:0], 1'b1};
            end else begin
              p_hi_d = shifted[31:0];
              p_lo_d = {p_lo_q[30:0], 1'b0};
            end
          end else begin
            p_hi_d = add_sum[32:1];
            p_lo_d = {add_sum[0], p_lo_q[31:1]};
          end
`else
          p_hi_d = add_sum[32:1];
          p_lo_d = {add_sum[0], p_lo_q[31:1]};
`endif
        end
        FIN: begin
          state_d = IDLE;
          done_d  = 1'b1;
`ifdef MULDIV_DIV_EN
          if (is_div_q) begin
            // A zero divisor leaves |op_a| as remainder, so rem restores op_a itself.
            lo_d = b_zero_q ? 32'hFFFF_FFFF : quot;
            hi_d = rem;
          end else begin
            {hi_d, lo_d} = prod;
          end
`else
          {hi_d, lo_d} = prod;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // NOTE: datapath registers skip reset; accept always loads them before CALC reads them.
  always_ff @(posedge clk) begin
    mb_q   <= mb_d;
    p_hi_q <= p_hi_d;
    p_lo_q <= p_lo_d;
    sa_q   <= sa_d;
    sb_q   <= sb_d;
`ifdef MULDIV_DIV_EN
    is_div_q <= is_div_d;
    b_zero_q <= b_zero_d;
`endif
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter: none; datapath width fixed at 32 bits.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op_valid  in  1  EXE-stage multiply/divide request, held until accepted.
REQ-005 op_type  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 op_a, op_b  in  32 each  rs_value / rt_value operands.
REQ-007 mthi, mtlo  in  1 each  HI/LO write request; mt_data in 32 carries the value.
REQ-008 mf_req  in  1  MFHI/MFLO in EXE needs HI/LO.
REQ-009 flush  in  1  exception/ERET cancel of in-flight operation.
REQ-010 busy  out  1  engine not idle.
REQ-011 stall  out  1  hold EXE and upstream stages.
REQ-012 done  out  1  one-cycle pulse: HI/LO hold a fresh result.
REQ-013 hi, lo  out  32 each  architectural HI/LO registers.

Function
REQ-014 FSM states IDLE, CALC, FIN; busy = (state != IDLE).
REQ-015 Accept when op_valid & ~busy & ~flush in cycle N; operands latched as magnitudes plus sign flags (signed ops only); 5-bit counter cleared.
REQ-016 CALC lasts exactly 32 cycles (N+1..N+32): one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step per cycle; counter wraps 31->0 into FIN.
REQ-017 FIN (N+33): sign correction; HI/LO written at end of FIN; state -> IDLE.
REQ-018 done high only in cycle N+34, with new hi/lo visible; total latency 34 cycles.
REQ-019 Multiply: {hi,lo} = 64-bit product; MULT two's-complement, MULTU unsigned.
REQ-020 Divide: lo = quotient, hi = remainder; DIV quotient sign = sign(a) xor sign(b), remainder sign = sign(a); DIVU unsigned.
REQ-021 Divide-by-zero: full latency, lo = 32'hFFFF_FFFF, hi = op_a (signed and unsigned alike).
REQ-022 DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo = 32'h8000_0000, hi = 0.
REQ-023 stall = busy & (op_valid | mf_req | mthi | mtlo); combinational.
REQ-024 op_valid while busy is not accepted; requester holds it under stall.
REQ-025 mthi/mtlo while idle: hi/lo <= mt_data at that edge; both high writes both.
REQ-026 op_valid and mthi/mtlo same idle cycle: op accepted, mt write dropped.
REQ-027 flush in any busy cycle: state -> IDLE next edge, hi/lo unchanged, no done; flush in IDLE blocks acceptance that cycle.
REQ-028 No op accepted during FIN; next accept earliest at N+34.

Reset
REQ-029 reset high: state IDLE, counter 0, hi = lo = 0, done = 0, busy = 0, stall = 0; reset mid-operation abandons it with no done pulse.
REQ-030 reset dominates flush, op_valid and mthi/mtlo in the same cycle.

Configuration
REQ-031 Macro MULDIV_DIV_EN defined: divider datapath present, REQ-020..022 apply.
REQ-032 MULDIV_DIV_EN undefined: divider logic absent; DIV/DIVU never accepted, no busy, no done, hi/lo unchanged; multiply behaviour identical.

Verification
REQ-033 MULTU 0xFFFF_FFFF x 0xFFFF_FFFF accepted at N -> done at N+34, hi = 0xFFFF_FFFE, lo = 0x0000_0001.
REQ-034 MULT -3 x 7 -> hi = 0xFFFF_FFFF, lo = 0xFFFF_FFEB; DIV -7 / 2 -> lo = 0xFFFF_FFFD, hi = 0xFFFF_FFFF.
REQ-035 DIVU 7 / 0 -> lo = 0xFFFF_FFFF, hi = 0x0000_0007 at N+34.
REQ-036 mf_req high from N+1 -> stall high N+1..N+33, low at N+34.
REQ-037 flush at N+10 -> busy low at N+11, hi/lo retain prior values, done never pulses; reset at N+20 -> hi = lo = 0 next cycle.
REQ-038 Build without MULDIV_DIV_EN, issue DIV 8 / 2 -> busy and done stay 0, hi/lo unchanged.
